// File: rtl/dino_pkg.sv
// Shared types and constants for the dino runner game core.
package dino_pkg;

  typedef enum logic [1:0] {
    JS_GROUND = 2'd0,
    JS_RISE   = 2'd1,
    JS_AIR    = 2'd2,
    JS_FALL   = 2'd3
  } jump_state_e;

  // Lane column the dino occupies.
  localparam int DINO_COL = 1;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] Y_GROUND = 2'd0;
  localparam logic [1:0] Y_MID    = 2'd1;
  localparam logic [1:0] Y_APEX   = 2'd2;

  // Shift left by one, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Height shown on the display for each jump state.
  function automatic logic [1:0] jump_height(input jump_state_e s);
    logic [1:0] h;
    case (s)
      JS_RISE: h = Y_MID;
      JS_AIR:  h = Y_APEX;
      JS_FALL: h = Y_MID;
      default: h = Y_GROUND;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  output logic [15:0] state
);
  import dino_pkg::*;

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next value: step only when enabled.
  always_comb begin
    state_d = state_q;
    if (step_en) state_d = lfsr_next(state_q);
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/dino_obstacle_engine.sv
// Dino runner game core: tick divider, scrolling obstacle lane, jump FSM,
// collision and pass scoring with sticky terminal flags.
module dino_obstacle_engine #(
  parameter int          TICK_DIV  = 1_000_000,
  parameter int          LANE_W    = 16,
  parameter int          AIR_TICKS = 3,
  parameter int          OBST_GOAL = 20,
  parameter int          MIN_GAP   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_game,
  input  logic              key_jump,
  output logic              collision_detected,
  output logic              game_cleared,
  output logic [LANE_W-1:0] lane,
  output logic [1:0]        dino_y,
  output logic [7:0]        score,
  output logic              tick
);
  import dino_pkg::*;

  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int AIR_W  = (AIR_TICKS > 1) ? $clog2(AIR_TICKS + 1) : 1;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP);
  localparam logic [AIR_W-1:0]  AIR_LOAD  = AIR_W'(AIR_TICKS - 1);
  localparam logic [7:0]        GOAL      = 8'(OBST_GOAL);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              run_prev_q, key_prev_q;
  logic              pend_q, pend_d;
  jump_state_e       state_q, state_d;
  logic [AIR_W-1:0]  air_q, air_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [7:0]        score_q, score_d;
  logic [1:0]        y_q, y_d;
  logic              coll_q, coll_d;
  logic              clr_q, clr_d;
  logic              tick_q, tick_d;

  logic              frozen, new_game, key_rise, tick_now;
  logic              exit_obst, spawn;
  logic [7:0]        score_inc;
  logic [15:0]       lfsr_state;
  logic              unused_lfsr_hi;

  assign frozen   = ~run_game | coll_q | clr_q;
  assign new_game = run_game & ~run_prev_q & (coll_q | clr_q);
  assign key_rise = key_jump & ~key_prev_q;
  assign tick_now = ~frozen & (tcnt_q == TCNT_LAST);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_en (tick_now),
    .state   (lfsr_state)
  );

  // Only the low bits gate spawning; the rest just carry the sequence.
  assign unused_lfsr_hi = ^lfsr_state[15:3];

  // Game step: new-game clear, per-tick lane/jump/score update, divider count.
  always_comb begin
    tcnt_d    = tcnt_q;
    state_d   = state_q;
    air_d     = air_q;
    gap_d     = gap_q;
    lane_d    = lane_q;
    score_d   = score_q;
    y_d       = y_q;
    coll_d    = coll_q;
    clr_d     = clr_q;
    tick_d    = 1'b0;
    exit_obst = 1'b0;
    spawn     = 1'b0;
    score_inc = score_q;

    // A press landing on the tick cycle survives to the next tick.
    pend_d = tick_now ? key_rise : (pend_q | key_rise);

    if (new_game) begin
      coll_d  = 1'b0;
      clr_d   = 1'b0;
      lane_d  = '0;
      score_d = '0;
      state_d = JS_GROUND;
      air_d   = '0;
      y_d     = Y_GROUND;
      tcnt_d  = '0;
      gap_d   = '0;
    end else if (tick_now) begin
      tcnt_d    = '0;
      tick_d    = 1'b1;
      exit_obst = lane_q[0];
      spawn     = (lfsr_state[2:0] == 3'd0) && (gap_q == '0);
      lane_d    = {spawn, lane_q[LANE_W-1:1]};
      if (spawn)             gap_d = GAP_LOAD;
      else if (gap_q != '0)  gap_d = gap_q - 1'b1;

      case (state_q)
        JS_GROUND: if (pend_q) state_d = JS_RISE;
        JS_RISE: begin
          state_d = JS_AIR;
          air_d   = AIR_LOAD;
        end
        JS_AIR: begin
          if (air_q == '0) state_d = JS_FALL;
          else             air_d   = air_q - 1'b1;
        end
        JS_FALL:  state_d = JS_GROUND;
        default:  state_d = JS_GROUND;
      endcase
      y_d = jump_height(state_d);

      // A hit outranks a pass or clear decided on the same tick.
      if (lane_d[DINO_COL] && (y_d == Y_GROUND)) begin
        coll_d = 1'b1;
      end else if (exit_obst) begin
        score_inc = (score_q == 8'd255) ? score_q : score_q + 8'd1;
        score_d   = score_inc;
        if (score_inc >= GOAL) clr_d = 1'b1;
      end
    end else if (!frozen) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q     <= '0;
      run_prev_q <= 1'b0;
      key_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      state_q    <= JS_GROUND;
      air_q      <= '0;
      gap_q      <= '0;
      lane_q     <= '0;
      score_q    <= '0;
      y_q        <= Y_GROUND;
      coll_q     <= 1'b0;
      clr_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      run_prev_q <= run_game;
      key_prev_q <= key_jump;
      pend_q     <= pend_d;
      state_q    <= state_d;
      air_q      <= air_d;
      gap_q      <= gap_d;
      lane_q     <= lane_d;
      score_q    <= score_d;
      y_q        <= y_d;
      coll_q     <= coll_d;
      clr_q      <= clr_d;
      tick_q     <= tick_d;
    end
  end

  assign collision_detected = coll_q;
  assign game_cleared       = clr_q;
  assign lane               = lane_q;
  assign dino_y             = y_q;
  assign score              = score_q;
  assign tick               = tick_q;

endmodule
